// File: rtl/robo_pkg.sv
// Shared types for the wall-follower motion sequencer: FSM state encoding
// and the 4-bit wheel command words {l_en, l_rev, r_en, r_rev}.
package robo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FORWARD = 3'd1,
        ST_TURN    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] MOT_OFF    = 4'b0000;
    localparam logic [3:0] MOT_FWD    = 4'b1010;
    localparam logic [3:0] MOT_SPIN_R = 4'b1011;

endpackage

// File: rtl/robo_cycle_timer.sv
// Loadable down-counter that times each motion phase; it parks at zero
// rather than wrapping so idle states keep a stable zero flag.
module robo_cycle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clock) begin
        if (reset)
            r_value <= '0;
        else if (i_load)
            r_value <= i_load_val;
        else if (r_value != '0)
            r_value <= r_value - CNT_W'(1);
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);

endmodule

// File: rtl/robo_motion_sequencer.sv
// Turns avancar/girar decisions into timed wheel drive with a settle gap,
// bump abort on forward moves and a halt after too many consecutive turns.
module robo_motion_sequencer
    import robo_pkg::*;
#(
    parameter int FWD_CYCLES    = 8,
    parameter int TURN_CYCLES   = 12,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_TURNS     = 4,
    parameter int CNT_W         = 8,
    parameter int TC_W          = $clog2(MAX_TURNS+1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            avancar,
    input  logic            girar,
    input  logic            head,
    input  logic            clear_stuck,
    output logic            motor_left_en,
    output logic            motor_left_rev,
    output logic            motor_right_en,
    output logic            motor_right_rev,
    output logic            busy,
    output logic            step_done,
    output logic            bumped,
    output logic            stuck,
    output logic [TC_W-1:0] turn_count
);

    localparam logic [CNT_W-1:0] FWD_LD    = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TC_W-1:0]  TC_MAX    = TC_W'(MAX_TURNS);

    state_t           r_state, w_next;
    logic             w_load, w_bump, w_tmr_zero;
    logic [CNT_W-1:0] w_load_val, w_tmr_value, w_tmr_next;
    logic [TC_W-1:0]  r_turn_count, w_tc_next, w_tc_inc;
    logic [3:0]       r_mot, w_mot;
    logic             r_busy, r_step_done, r_bumped, r_stuck;
    logic             w_busy, w_step_done, w_stuck;

    robo_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_value    (w_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_turn_count <= '0;
        end else begin
            r_state      <= w_next;
            r_turn_count <= w_tc_next;
        end
    end

    assign w_tc_inc = (r_turn_count == TC_MAX) ? r_turn_count : r_turn_count + TC_W'(1);

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_tc_next  = r_turn_count;
        w_bump     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (girar) begin
                    w_next     = ST_TURN;
                    w_load     = 1'b1;
                    w_load_val = TURN_LD;
                end else if (avancar) begin
                    w_next     = ST_FORWARD;
                    w_load     = 1'b1;
                    w_load_val = FWD_LD;
                end
            end
            ST_FORWARD: begin
                // A bump still counts as a forward move, so the turn streak resets.
                if (head || w_tmr_zero) begin
                    w_next     = ST_SETTLE;
                    w_load     = 1'b1;
                    w_load_val = SETTLE_LD;
                    w_tc_next  = '0;
                    w_bump     = head;
                end
            end
            ST_TURN: begin
                if (w_tmr_zero) begin
                    w_tc_next = w_tc_inc;
                    if (w_tc_inc == TC_MAX) begin
                        w_next = ST_HALT;
                    end else begin
                        w_next     = ST_SETTLE;
                        w_load     = 1'b1;
                        w_load_val = SETTLE_LD;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero)
                    w_next = ST_IDLE;
            end
            ST_HALT: begin
                if (clear_stuck) begin
                    w_next    = ST_IDLE;
                    w_tc_next = '0;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and timer so they land in the
    // same cycle the state takes effect.
    assign w_tmr_next = w_load ? w_load_val :
                        (w_tmr_zero ? '0 : w_tmr_value - CNT_W'(1));

    always_comb begin
        w_mot       = MOT_OFF;
        w_busy      = (w_next != ST_IDLE);
        w_stuck     = (w_next == ST_HALT);
        w_step_done = (w_next == ST_SETTLE) && (w_tmr_next == '0);
        case (w_next)
            ST_FORWARD: w_mot = MOT_FWD;
            ST_TURN:    w_mot = MOT_SPIN_R;
            default:    w_mot = MOT_OFF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mot       <= MOT_OFF;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
            r_bumped    <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_mot       <= w_mot;
            r_busy      <= w_busy;
            r_step_done <= w_step_done;
            r_bumped    <= w_bump;
            r_stuck     <= w_stuck;
        end
    end

    assign motor_left_en   = r_mot[3];
    assign motor_left_rev  = r_mot[2];
    assign motor_right_en  = r_mot[1];
    assign motor_right_rev = r_mot[0];
    assign busy            = r_busy;
    assign step_done       = r_step_done;
    assign bumped          = r_bumped;
    assign stuck           = r_stuck;
    assign turn_count      = r_turn_count;

endmodule

// File: tb/tb_robo_motion_sequencer.sv
// Directed bench for the motion sequencer: forward, turn, bump, stuck/halt,
// command priority and mid-move reset, with hand-derived cycle timing.
module tb_robo_motion_sequencer;

    logic       clock = 1'b0;
    logic       reset, avancar, girar, head, clear_stuck;
    logic       motor_left_en, motor_left_rev, motor_right_en, motor_right_rev;
    logic       busy, step_done, bumped, stuck;
    logic [2:0] turn_count;
    logic [3:0] mot;
    int         checks   = 0;
    int         failures = 0;

    robo_motion_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .avancar         (avancar),
        .girar           (girar),
        .head            (head),
        .clear_stuck     (clear_stuck),
        .motor_left_en   (motor_left_en),
        .motor_left_rev  (motor_left_rev),
        .motor_right_en  (motor_right_en),
        .motor_right_rev (motor_right_rev),
        .busy            (busy),
        .step_done       (step_done),
        .bumped          (bumped),
        .stuck           (stuck),
        .turn_count      (turn_count)
    );

    always #5 clock = ~clock;
    assign mot = {motor_left_en, motor_left_rev, motor_right_en, motor_right_rev};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; avancar = 1'b0; girar = 1'b0; head = 1'b0; clear_stuck = 1'b0;
        tick(); tick();
        checks++;
        if ({mot, busy, step_done, bumped, stuck, turn_count} !== 11'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {mot, busy, step_done, bumped, stuck, turn_count});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
    endtask

    task automatic test_forward();
        avancar = 1'b1; tick(); avancar = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (mot !== 4'b1010 || busy !== 1'b1 || step_done !== 1'b0) begin
                failures++;
                $display("FAIL fwd_drive cyc=%0d mot=%b busy=%b sd=%b want 1010/1/0", i, mot, busy, step_done);
            end
            tick();
        end
        checks++;
        if (mot !== 4'b0000 || step_done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL fwd_settle1 mot=%b sd=%b busy=%b want 0000/0/1", mot, step_done, busy);
        end
        tick();
        checks++;
        if (mot !== 4'b0000 || step_done !== 1'b1) begin
            failures++; $display("FAIL fwd_step_done mot=%b sd=%b want 0000/1", mot, step_done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || step_done !== 1'b0 || turn_count !== 3'd0) begin
            failures++; $display("FAIL fwd_idle busy=%b sd=%b tc=%0d want 0/0/0", busy, step_done, turn_count);
        end
    endtask

    task automatic test_turn();
        girar = 1'b1; tick(); girar = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            checks++;
            if (mot !== 4'b1011 || turn_count !== 3'd0) begin
                failures++; $display("FAIL turn_drive cyc=%0d mot=%b tc=%0d want 1011/0", i, mot, turn_count);
            end
            tick();
        end
        checks++;
        if (mot !== 4'b0000 || turn_count !== 3'd1 || step_done !== 1'b0) begin
            failures++; $display("FAIL turn_settle1 mot=%b tc=%0d sd=%b want 0000/1/0", mot, turn_count, step_done);
        end
        tick();
        checks++;
        if (step_done !== 1'b1) begin failures++; $display("FAIL turn_step_done sd=%b want 1", step_done); end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL turn_idle busy=%b want 0", busy); end
    endtask

    task automatic test_bump();
        avancar = 1'b1; tick(); avancar = 1'b0;
        tick(); tick();
        checks++;
        if (mot !== 4'b1010 || bumped !== 1'b0) begin
            failures++; $display("FAIL bump_pre mot=%b bumped=%b want 1010/0", mot, bumped);
        end
        head = 1'b1; tick(); head = 1'b0;
        checks++;
        if (mot !== 4'b0000 || bumped !== 1'b1 || turn_count !== 3'd0 || busy !== 1'b1 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL bump_abort mot=%b bumped=%b tc=%0d busy=%b sd=%b want 0000/1/0/1/0", mot, bumped, turn_count, busy, step_done);
        end
        tick();
        checks++;
        if (bumped !== 1'b0 || step_done !== 1'b1) begin
            failures++; $display("FAIL bump_settle bumped=%b sd=%b want 0/1", bumped, step_done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL bump_idle busy=%b want 0", busy); end
    endtask

    task automatic test_stuck();
        for (int k = 1; k <= 4; k++) begin
            girar = 1'b1; tick(); girar = 1'b0;
            for (int i = 2; i <= 12; i++) tick();
            checks++;
            if (mot !== 4'b1011) begin failures++; $display("FAIL stuck_turn%0d_last mot=%b want 1011", k, mot); end
            tick();
            if (k < 4) begin
                checks++;
                if (turn_count !== 3'(k) || stuck !== 1'b0 || mot !== 4'b0000) begin
                    failures++; $display("FAIL stuck_turn%0d tc=%0d stuck=%b mot=%b want %0d/0/0000", k, turn_count, stuck, mot, k);
                end
                tick(); tick();
            end
        end
        checks++;
        if (stuck !== 1'b1 || busy !== 1'b1 || mot !== 4'b0000 || turn_count !== 3'd4 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL stuck_halt stuck=%b busy=%b mot=%b tc=%0d sd=%b want 1/1/0000/4/0", stuck, busy, mot, turn_count, step_done);
        end
        avancar = 1'b1; girar = 1'b1; head = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (stuck !== 1'b1 || mot !== 4'b0000 || step_done !== 1'b0) begin
                failures++; $display("FAIL stuck_hold stuck=%b mot=%b sd=%b want 1/0000/0", stuck, mot, step_done);
            end
        end
        avancar = 1'b0; girar = 1'b0; head = 1'b0;
        clear_stuck = 1'b1; tick(); clear_stuck = 1'b0;
        checks++;
        if (stuck !== 1'b0 || busy !== 1'b0 || turn_count !== 3'd0) begin
            failures++; $display("FAIL stuck_clear stuck=%b busy=%b tc=%0d want 0/0/0", stuck, busy, turn_count);
        end
    endtask

    task automatic test_priority_busy();
        clear_stuck = 1'b1; tick(); clear_stuck = 1'b0;
        checks++;
        if (busy !== 1'b0 || stuck !== 1'b0) begin
            failures++; $display("FAIL clear_outside_halt busy=%b stuck=%b want 0/0", busy, stuck);
        end
        avancar = 1'b1; girar = 1'b1; tick();
        for (int i = 1; i <= 12; i++) begin
            avancar = i[0]; girar = i[1]; head = i[2];
            if (i == 12) begin avancar = 1'b0; girar = 1'b0; head = 1'b0; end
            checks++;
            if (mot !== 4'b1011) begin failures++; $display("FAIL both_turn cyc=%0d mot=%b want 1011", i, mot); end
            tick();
        end
        checks++;
        if (mot !== 4'b0000 || turn_count !== 3'd1 || bumped !== 1'b0) begin
            failures++; $display("FAIL both_end mot=%b tc=%0d bumped=%b want 0000/1/0", mot, turn_count, bumped);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL both_idle busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        avancar = 1'b1; tick();
        for (int i = 2; i <= 5; i++) tick();
        checks++;
        if (mot !== 4'b1010 || turn_count !== 3'd1) begin
            failures++; $display("FAIL rst_mid_pre mot=%b tc=%0d want 1010/1", mot, turn_count);
        end
        reset = 1'b1; tick();
        checks++;
        if ({mot, busy, step_done, bumped, stuck, turn_count} !== 11'b0) begin
            failures++; $display("FAIL rst_mid_outputs got=%b want=0", {mot, busy, step_done, bumped, stuck, turn_count});
        end
        reset = 1'b0; tick(); avancar = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (mot !== 4'b1010) begin failures++; $display("FAIL rst_mid_restart cyc=%0d mot=%b want 1010", i, mot); end
            tick();
        end
        checks++;
        if (mot !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_stop mot=%b busy=%b want 0000/1", mot, busy);
        end
        tick();
        checks++;
        if (step_done !== 1'b1) begin failures++; $display("FAIL rst_mid_step_done sd=%b want 1", step_done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_turn();
        test_bump();
        test_stuck();
        test_priority_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
